// File: rtl/lut_reader_pkg.sv
// Shared types and constants for the LUT stream reader.
package lut_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Supported ROM read latencies: plain array, or array with output register.
  localparam int RD_LAT_NOREG = 1;
  localparam int RD_LAT_OREG  = 2;

  // Reads in flight occupy RD_LATENCY+1 tag stages, so the counter spans 0..RD_LATENCY+1.
  function automatic int inflight_width(input int rd_latency);
    return $clog2(rd_latency + 2);
  endfunction

endpackage

// File: rtl/lut_reader_fifo.sv
// Output buffer: storage array plus a registered head word that drives the stream.
// count tracks words held in the storage array only; the head register is a
// separate stage, refilled from storage whenever it is empty or being popped.
module lut_reader_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    push_last,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic                    out_valid,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    take
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;

  // Move a word from storage into the head register when the head is free.
  assign take = (count != '0) && (!out_valid || pop);

  // Storage array write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_last, push_data};
  end

  // Pointers and occupancy; the caller guarantees no push into a full array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (take) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(take);
    end
  end

  // Head register: data holds while stalled, last is cleared when emptied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (take) begin
      {out_last, out_data} <= mem[rd_ptr];
      out_valid            <= 1'b1;
    end else if (pop) begin
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lut_stream_reader.sv
// Walks a contiguous ROM window, absorbs the ROM read latency and presents the
// words as a valid/ready stream with a last marker. RD_LATENCY must be 1 or 2.
module lut_stream_reader
  import lut_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = RD_LAT_NOREG,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam int IFW  = inflight_width(RD_LATENCY);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int CRW  = ((IFW > CNTW) ? IFW : CNTW) + 1;
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] next_addr, issue_addr;
  logic [ADDR_WIDTH:0]   remaining, issue_rem;
  logic [RD_LATENCY:0]   tag_sr, last_sr;
  logic [IFW-1:0]        inflight;
  logic [CNTW-1:0]       fifo_count;
  logic                  fifo_take, pop, last_hs, write, credit_ok;
  logic                  accept, issue, issue_last, zero_done;

  assign accept  = (state == IDLE) && start && (length != '0);
  assign pop     = m_valid & m_ready;
  assign last_hs = pop & m_last;
  assign write   = tag_sr[RD_LATENCY];

  // A head refill in this cycle frees a storage slot, so it counts as credit.
  assign credit_ok = (CRW'(inflight) + CRW'(fifo_count) - CRW'(fifo_take)) < CRW'(FIFO_DEPTH);

  // The accepting cycle issues the base address itself; later issues use the counters.
  assign issue_addr = (state == IDLE) ? base_addr : next_addr;
  assign issue_rem  = (state == IDLE) ? length : remaining;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: a one-word window skips straight to DRAIN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (length == LEN_ONE) ? DRAIN : ISSUE;
      ISSUE:   if (issue && remaining == LEN_ONE) state_nxt = DRAIN;
      DRAIN:   if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: issue strobe, its last flag, status.
  always_comb begin
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state)
      IDLE: begin
        issue      = accept;
        issue_last = (length == LEN_ONE);
      end
      ISSUE: begin
        issue      = credit_ok;
        issue_last = (remaining == LEN_ONE);
      end
      default: ;
    endcase
    busy = (state != IDLE);
    done = zero_done | ((state == DRAIN) & last_hs);
  end

  // Address/remaining counters, latency tag pipeline and in-flight count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr  <= '0;
      next_addr <= '0;
      remaining <= '0;
      tag_sr    <= '0;
      last_sr   <= '0;
      inflight  <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= (state == IDLE) && start && (length == '0);
      if (issue) begin
        rom_addr  <= issue_addr;
        next_addr <= issue_addr + 1'b1;
        remaining <= issue_rem - 1'b1;
      end
      tag_sr   <= {tag_sr[RD_LATENCY-1:0], issue};
      last_sr  <= {last_sr[RD_LATENCY-1:0], issue & issue_last};
      inflight <= inflight + IFW'(issue) - IFW'(write);
    end
  end

  lut_reader_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (write),
    .push_data(rom_rd_data),
    .push_last(last_sr[RD_LATENCY]),
    .pop      (pop),
    .out_data (m_data),
    .out_last (m_last),
    .out_valid(m_valid),
    .count    (fifo_count),
    .take     (fifo_take)
  );

endmodule
